// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port plus
// the valid/ready slot that hands instructions to decode.
interface pc_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i,
        output inst_valid_o,
        output inst_o,
        output inst_pc_o,
        input  inst_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i,
        input  inst_valid_o,
        input  inst_o,
        input  inst_pc_o,
        output inst_ready_i
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: PC+4 stepping, redirect flush, stall.
// Optional PC_MISALIGN_TRAP_EN: trap misaligned redirect targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    output logic                   misalign_o,
    pc_fetch_unit_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic        ack;
    logic        slot_free;
    logic        issue_ok;
    logic        bad_tgt;
    logic [31:0] tgt;

    assign ack       = bus.imem_ack_i;
    assign slot_free = !valid_q || bus.inst_ready_i;
    assign issue_ok  = !stall_i && slot_free;

    // Redirect target resolution (trap keeps the old pc).
    always_comb begin
        bad_tgt = 1'b0;
        tgt     = redirect_pc_i & ~32'h3;
`ifdef PC_MISALIGN_TRAP_EN
        if (redirect_pc_i[1:0] != 2'b00) begin
            bad_tgt = redirect_i;
            tgt     = pc_q;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    state_d = stall_i ? S_IDLE : S_REQ;
                end else if (issue_ok) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_i) begin
                    state_d = ack ? S_IDLE : S_DROP;
                end else if (ack) begin
                    state_d = issue_ok ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and datapath registers.
    always_comb begin
        bus.imem_req_o   = (state_q != S_IDLE);
        bus.imem_addr_o  = addr_q;
        bus.inst_valid_o = valid_q;
        bus.inst_o       = inst_q;
        bus.inst_pc_o    = inst_pc_q;
    end

    // Datapath next values: pc, fetch address and output slot.
    always_comb begin
        pc_d      = pc_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (valid_q && bus.inst_ready_i) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
        if (redirect_i) begin
            pc_d    = tgt;
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            if (state_q == S_IDLE && !stall_i) begin
                addr_d = tgt;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (issue_ok) begin
                        addr_d = pc_q;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        inst_d    = bus.imem_rdata_i;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        if (issue_ok) begin
                            addr_d = pc_q + 32'd4;
                        end
                    end
                end
                S_DROP: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= NOP_INST;
            inst_pc_q <= 32'h0;
        end else begin
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    // One-cycle pulse on a misaligned redirect.
    always_comb begin
        misalign_d = bad_tgt;
    end

    // Misalign flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = bad_tgt;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, stall,
// backpressure, redirect/drop, wrap and misaligned targets.
module tb_pc_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        misalign_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .misalign_o   (misalign_o),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic ack, input logic [31:0] a);
        bus.imem_ack_i   = ack;
        bus.imem_rdata_i = ack ? mdata(a) : 32'h0;
    endtask

    logic [31:0] exp_pc6;
    logic        exp_mis6;

    initial begin
        rst_n             = 1'b0;
        stall_i           = 1'b0;
        redirect_i        = 1'b0;
        redirect_pc_i     = 32'h0;
        bus.imem_ack_i    = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.inst_ready_i  = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        exp_pc6  = 32'h0000_0000;
        exp_mis6 = 1'b1;
`else
        exp_pc6  = 32'h0000_0100;
        exp_mis6 = 1'b0;
`endif

        step();
        step();
        chk("rst_req",   {31'h0, bus.imem_req_o},   32'h0);
        chk("rst_addr",  bus.imem_addr_o,           32'h0);
        chk("rst_valid", {31'h0, bus.inst_valid_o}, 32'h0);
        chk("rst_inst",  bus.inst_o,                32'h13);
        chk("rst_ipc",   bus.inst_pc_o,             32'h0);
        chk("rst_mis",   {31'h0, misalign_o},       32'h0);

        rst_n = 1'b1;
        step();
        chk("t1_req0",  {31'h0, bus.imem_req_o}, 32'h1);
        chk("t1_addr0", bus.imem_addr_o,         32'h0);
        drive(1'b1, 32'h0);
        step();
        chk("t1_val0",  {31'h0, bus.inst_valid_o}, 32'h1);
        chk("t1_inst0", bus.inst_o,                mdata(32'h0));
        chk("t1_ipc0",  bus.inst_pc_o,             32'h0);
        chk("t1_addr4", bus.imem_addr_o,           32'h4);
        drive(1'b1, 32'h4);
        step();
        chk("t1_inst4", bus.inst_o,      mdata(32'h4));
        chk("t1_ipc4",  bus.inst_pc_o,   32'h4);
        chk("t1_addr8", bus.imem_addr_o, 32'h8);
        drive(1'b1, 32'h8);
        stall_i = 1'b1;
        step();
        chk("t1_inst8", bus.inst_o,              mdata(32'h8));
        chk("t1_ipc8",  bus.inst_pc_o,           32'h8);
        chk("t1_stall", {31'h0, bus.imem_req_o}, 32'h0);

        drive(1'b0, 32'h0);
        stall_i          = 1'b0;
        bus.inst_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_req",  {31'h0, bus.imem_req_o}, 32'h0);
            chk("t2_inst", bus.inst_o,              mdata(32'h8));
            chk("t2_ipc",  bus.inst_pc_o,           32'h8);
        end
        bus.inst_ready_i = 1'b1;
        step();
        chk("t2_req",   {31'h0, bus.imem_req_o},   32'h1);
        chk("t2_addr",  bus.imem_addr_o,           32'hC);
        chk("t2_drain", {31'h0, bus.inst_valid_o}, 32'h0);

        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        chk("t3_val",   {31'h0, bus.inst_valid_o}, 32'h0);
        chk("t3_dreq",  {31'h0, bus.imem_req_o},   32'h1);
        chk("t3_daddr", bus.imem_addr_o,           32'hC);
        step();
        drive(1'b1, 32'hC);
        step();
        drive(1'b0, 32'h0);
        chk("t3_disc", {31'h0, bus.inst_valid_o}, 32'h0);
        chk("t3_idle", {31'h0, bus.imem_req_o},   32'h0);
        step();
        chk("t3_req",  {31'h0, bus.imem_req_o},   32'h1);
        chk("t3_addr", bus.imem_addr_o,           32'h100);
        chk("t3_val2", {31'h0, bus.inst_valid_o}, 32'h0);

        drive(1'b1, 32'h100);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        drive(1'b0, 32'h0);
        redirect_i = 1'b0;
        chk("t4_val",  {31'h0, bus.inst_valid_o}, 32'h0);
        chk("t4_inst", bus.inst_o,                32'h13);
        chk("t4_nodr", {31'h0, bus.imem_req_o},   32'h0);
        step();
        chk("t4_req",  {31'h0, bus.imem_req_o}, 32'h1);
        chk("t4_addr", bus.imem_addr_o,         32'h200);
        drive(1'b1, 32'h200);
        step();
        chk("t4_inst2", bus.inst_o,    mdata(32'h200));
        chk("t4_ipc2",  bus.inst_pc_o, 32'h200);

        drive(1'b1, 32'h204);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        drive(1'b0, 32'h0);
        redirect_i = 1'b0;
        step();
        chk("t5_req",  {31'h0, bus.imem_req_o}, 32'h1);
        chk("t5_addr", bus.imem_addr_o,         32'hFFFF_FFFC);
        drive(1'b1, 32'hFFFF_FFFC);
        step();
        chk("t5_ipc",  bus.inst_pc_o,   32'hFFFF_FFFC);
        chk("t5_inst", bus.inst_o,      mdata(32'hFFFF_FFFC));
        chk("t5_wrap", bus.imem_addr_o, 32'h0);

        drive(1'b1, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        step();
        drive(1'b0, 32'h0);
        redirect_i = 1'b0;
        chk("t6_mis1", {31'h0, misalign_o},       {31'h0, exp_mis6});
        chk("t6_val",  {31'h0, bus.inst_valid_o}, 32'h0);
        step();
        chk("t6_mis0", {31'h0, misalign_o},       32'h0);
        chk("t6_req",  {31'h0, bus.imem_req_o},   32'h1);
        chk("t6_addr", bus.imem_addr_o,           exp_pc6);

        drive(1'b1, exp_pc6);
        rst_n = 1'b0;
        #1;
        chk("t7_req",   {31'h0, bus.imem_req_o},   32'h0);
        chk("t7_addr",  bus.imem_addr_o,           32'h0);
        chk("t7_valid", {31'h0, bus.inst_valid_o}, 32'h0);
        chk("t7_inst",  bus.inst_o,                32'h13);
        step();
        chk("t7_ack",   {31'h0, bus.inst_valid_o}, 32'h0);
        drive(1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
